// File: rtl/i2c_apb_arbiter.sv
// Round-robin arbiter sharing one APB master port between two requesters.
// Optional PREADY timeout is built when I2C_APB_ARB_TIMEOUT_EN is defined.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   S_IDLE   | waiting for a request; ready asserted here only
//   S_SETUP  | APB setup phase, PSEL=1 PENABLE=0, one cycle
//   S_ACCESS | APB access phase, waits for PREADY (or timeout)
//   S_RESP   | one-cycle response pulse to the granted requester
module i2c_apb_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        req0_valid,
   input  logic        req0_write,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        req0_ready,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_rdata,
   output logic        rsp0_err,
   input  logic        req1_valid,
   input  logic        req1_write,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        req1_ready,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_rdata,
   output logic        rsp1_err,
   output logic [31:0] M_PADDR,
   output logic [31:0] M_PWDATA,
   output logic        M_PWRITE,
   output logic        M_PSELx,
   output logic        M_PENABLE,
   input  logic        M_PREADY,
   input  logic        M_PSLVERR,
   input  logic [31:0] M_PRDATA,
   output logic        busy,
   output logic        grant,
   output logic        timeout
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_last_grant;
   logic        r_grant;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rsp0_rdata;
   logic [31:0] r_rsp1_rdata;
   logic        r_rsp0_err;
   logic        r_rsp1_err;

   logic        w_idle;
   logic        w_rdy0;
   logic        w_rdy1;
   logic        w_accept;
   logic        w_sel;
   logic        w_done_ok;
   logic        w_tmo;
   logic        w_rsp_upd;
   logic [31:0] w_rsp_rdata;
   logic        w_rsp_err;

   // On a tie the requester that did not own the last transfer wins.
   assign w_idle   = (r_state == S_IDLE);
   assign w_rdy0   = w_idle & req0_valid & (~req1_valid | r_last_grant);
   assign w_rdy1   = w_idle & req1_valid & (~req0_valid | ~r_last_grant);
   assign w_accept = w_rdy0 | w_rdy1;
   assign w_sel    = w_rdy1;

   assign w_done_ok = (r_state == S_ACCESS) & M_PREADY;

`ifdef I2C_APB_ARB_TIMEOUT_EN
   localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_cnt;
   logic       r_timeout;

   assign w_tmo = (r_state == S_ACCESS) & ~M_PREADY & (r_cnt == LP_TMO_LAST);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_cnt     <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_SETUP)
            r_cnt <= 8'd0;
         else if ((r_state == S_ACCESS) && !M_PREADY)
            r_cnt <= r_cnt + 8'd1;
         if (w_tmo)
            r_timeout <= 1'b1;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_tmo   = 1'b0;
   assign timeout = 1'b0;
`endif

   // A timeout looks like an error completion with zero read data.
   assign w_rsp_upd   = w_done_ok | w_tmo;
   assign w_rsp_rdata = (w_tmo | r_write) ? 32'd0 : M_PRDATA;
   assign w_rsp_err   = w_tmo | M_PSLVERR;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept)  w_next = S_SETUP;
         S_SETUP:                 w_next = S_ACCESS;
         S_ACCESS: if (w_rsp_upd) w_next = S_RESP;
         S_RESP:                  w_next = S_IDLE;
         default:                 w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_write      <= 1'b0;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_rsp0_rdata <= 32'd0;
         r_rsp1_rdata <= 32'd0;
         r_rsp0_err   <= 1'b0;
         r_rsp1_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_write      <= w_sel ? req1_write : req0_write;
            r_addr       <= w_sel ? req1_addr  : req0_addr;
            r_wdata      <= w_sel ? req1_wdata : req0_wdata;
         end
         // Registers load on the ACCESS->RESP edge so they are valid with rsp_valid.
         if (w_rsp_upd) begin
            if (r_grant) begin
               r_rsp1_rdata <= w_rsp_rdata;
               r_rsp1_err   <= w_rsp_err;
            end else begin
               r_rsp0_rdata <= w_rsp_rdata;
               r_rsp0_err   <= w_rsp_err;
            end
         end
      end
   end

   assign req0_ready = w_rdy0;
   assign req1_ready = w_rdy1;
   assign rsp0_valid = (r_state == S_RESP) & ~r_grant;
   assign rsp1_valid = (r_state == S_RESP) &  r_grant;
   assign rsp0_rdata = r_rsp0_rdata;
   assign rsp1_rdata = r_rsp1_rdata;
   assign rsp0_err   = r_rsp0_err;
   assign rsp1_err   = r_rsp1_err;

   assign M_PADDR   = r_addr;
   assign M_PWDATA  = r_wdata;
   assign M_PWRITE  = r_write;
   assign M_PSELx   = (r_state == S_SETUP) | (r_state == S_ACCESS);
   assign M_PENABLE = (r_state == S_ACCESS);
   assign busy      = ~w_idle;
   assign grant     = r_grant;

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Directed bench for i2c_apb_arbiter; follows I2C_APB_ARB_TIMEOUT_EN if defined.
module tb_i2c_apb_arbiter;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        req0_valid, req0_write, req1_valid, req1_write;
   logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
   logic        req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic [31:0] M_PADDR, M_PWDATA, M_PRDATA;
   logic        M_PWRITE, M_PSELx, M_PENABLE, M_PREADY, M_PSLVERR;
   logic        busy, grant, timeout;

   int n_chk  = 0;
   int n_pass = 0;

   i2c_apb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
      .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
      .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA), .M_PWRITE(M_PWRITE),
      .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE), .M_PREADY(M_PREADY),
      .M_PSLVERR(M_PSLVERR), .M_PRDATA(M_PRDATA),
      .busy(busy), .grant(grant), .timeout(timeout)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      PRESETn = 1'b0;
      req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
      req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
      M_PREADY = 1'b1; M_PSLVERR = 1'b0; M_PRDATA = 32'd0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_psel", M_PSELx, 0);
      chk("rst_paddr", M_PADDR, 0);
      chk("rst_grant", grant, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_rsp0_rdata", rsp0_rdata, 0);
      #10 PRESETn = 1'b1;
      tick();

      // Tie straight after reset: req0 wins first.
      req0_valid = 1; req0_write = 1; req0_addr = 32'h4; req0_wdata = 32'h11;
      req1_valid = 1; req1_write = 1; req1_addr = 32'hC; req1_wdata = 32'h22;
      #1;
      chk("tie1_rdy0", req0_ready, 1);
      chk("tie1_rdy1", req1_ready, 0);
      tick();
      req0_valid = 0;
      chk("tie1_grant", grant, 0);
      chk("tie1_paddr", M_PADDR, 32'h4);
      chk("tie1_rdy1_busy", req1_ready, 0);
      tick(); tick();
      chk("tie1_rsp0", rsp0_valid, 1);
      tick();
      chk("tie1_rdy1_t4", req1_ready, 1);
      tick();
      req1_valid = 0;
      chk("tie1_grant1", grant, 1);
      chk("tie1_paddr1", M_PADDR, 32'hC);
      chk("tie1_pwdata1", M_PWDATA, 32'h22);
      tick(); tick();
      chk("tie1_rsp1", rsp1_valid, 1);
      chk("tie1_rsp0_quiet", rsp0_valid, 0);
      tick();

      // Both again: last owner was req1, so req0 now.
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("tie2_rdy0", req0_ready, 1);
      chk("tie2_rdy1", req1_ready, 0);
      tick();
      req0_valid = 0;
      tick(); tick(); tick();
      chk("tie2_rdy1_next", req1_ready, 1);
      tick();
      req1_valid = 0;
      chk("tie2_grant", grant, 1);
      tick(); tick(); tick();

      // req0 write 0xA5 to 0x0, zero wait states.
      req0_valid = 1; req0_write = 1; req0_addr = 32'h0; req0_wdata = 32'hA5;
      #1;
      chk("wr_rdy0", req0_ready, 1);
      tick();
      req0_valid = 0;
      chk("wr_t1_psel", M_PSELx, 1);
      chk("wr_t1_pen", M_PENABLE, 0);
      chk("wr_t1_busy", busy, 1);
      tick();
      chk("wr_t2_psel", M_PSELx, 1);
      chk("wr_t2_pen", M_PENABLE, 1);
      chk("wr_t2_pwrite", M_PWRITE, 1);
      chk("wr_t2_pwdata", M_PWDATA, 32'hA5);
      chk("wr_t2_rsp0", rsp0_valid, 0);
      tick();
      chk("wr_t3_rsp0", rsp0_valid, 1);
      chk("wr_t3_err", rsp0_err, 0);
      chk("wr_t3_psel", M_PSELx, 0);
      tick();
      chk("wr_t4_rsp0", rsp0_valid, 0);
      chk("wr_t4_busy", busy, 0);
      chk("wr_t4_pwdata_hold", M_PWDATA, 32'hA5);

      // req1 read at 0x8 with three wait states.
      req1_valid = 1; req1_write = 0; req1_addr = 32'h8;
      tick();
      req1_valid = 0; M_PREADY = 0;
      chk("rd_t1_pwrite", M_PWRITE, 0);
      chk("rd_t1_paddr", M_PADDR, 32'h8);
      tick(); tick(); tick();
      chk("rd_t4_pen", M_PENABLE, 1);
      tick();
      chk("rd_t5_pen", M_PENABLE, 1);
      chk("rd_t5_rsp1", rsp1_valid, 0);
      M_PREADY = 1; M_PRDATA = 32'h12345678;
      tick();
      M_PRDATA = 32'h0;
      chk("rd_t6_rsp1", rsp1_valid, 1);
      chk("rd_t6_rdata", rsp1_rdata, 32'h12345678);
      chk("rd_t6_err", rsp1_err, 0);
      tick();
      chk("rd_rdata_hold", rsp1_rdata, 32'h12345678);

      // req1 write with PSLVERR, then a clean read.
      req1_valid = 1; req1_write = 1; req1_addr = 32'h10; req1_wdata = 32'hFF;
      tick();
      req1_valid = 0; M_PSLVERR = 1; M_PRDATA = 32'hFFFF_FFFF;
      tick(); tick();
      M_PSLVERR = 0; M_PRDATA = 32'h0;
      chk("err_rsp1", rsp1_valid, 1);
      chk("err_err", rsp1_err, 1);
      chk("err_rdata", rsp1_rdata, 32'h0);
      tick();
      req1_valid = 1; req1_write = 0; req1_addr = 32'h14;
      tick();
      req1_valid = 0; M_PRDATA = 32'hCAFE0001;
      tick(); tick();
      chk("ok_rsp1", rsp1_valid, 1);
      chk("ok_err", rsp1_err, 0);
      chk("ok_rdata", rsp1_rdata, 32'hCAFE0001);
      tick();

      // PREADY stuck low.
      req0_valid = 1; req0_write = 0; req0_addr = 32'h20;
      tick();
      req0_valid = 0; M_PREADY = 0;
      tick(); tick(); tick(); tick();
      chk("tmo_t5_pen", M_PENABLE, 1);
      tick();
`ifdef I2C_APB_ARB_TIMEOUT_EN
      chk("tmo_t6_rsp0", rsp0_valid, 1);
      chk("tmo_t6_err", rsp0_err, 1);
      chk("tmo_t6_rdata", rsp0_rdata, 0);
      chk("tmo_t6_psel", M_PSELx, 0);
      chk("tmo_t6_flag", timeout, 1);
      tick();
      chk("tmo_flag_sticky", timeout, 1);
      chk("tmo_idle", busy, 0);
      req0_valid = 1; req0_write = 0; req0_addr = 32'h24;
      tick();
      req0_valid = 0;
      tick();
`else
      chk("tmo_still_access", M_PENABLE, 1);
      chk("tmo_busy", busy, 1);
      chk("tmo_flag_low", timeout, 0);
      chk("tmo_no_rsp", rsp0_valid, 0);
      tick(); tick(); tick();
      chk("tmo_still_busy", busy, 1);
`endif

      // Reset asserted during ACCESS.
      chk("rst_mid_pen_pre", M_PENABLE, 1);
      PRESETn = 0;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_psel", M_PSELx, 0);
      chk("rst_mid_pen", M_PENABLE, 0);
      chk("rst_mid_paddr", M_PADDR, 0);
      chk("rst_mid_timeout", timeout, 0);
      chk("rst_mid_rsp0_err", rsp0_err, 0);
      M_PREADY = 1;
      tick();
      chk("rst_mid_rsp0", rsp0_valid, 0);
      PRESETn = 1;
      tick();
      chk("rst_mid_rsp0_after", rsp0_valid, 0);
      req0_valid = 1; req0_write = 0; req0_addr = 32'h18;
      #1;
      chk("post_rst_rdy0", req0_ready, 1);
      tick();
      req0_valid = 0; M_PRDATA = 32'hDEADBEEF;
      tick(); tick();
      chk("post_rst_rsp0", rsp0_valid, 1);
      chk("post_rst_rdata", rsp0_rdata, 32'hDEADBEEF);
      chk("post_rst_err", rsp0_err, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/i2c_apb_arbiter.md
# i2c_apb_arbiter

Two-port APB master arbiter that shares the single APB slave port of the `i2c` top between two requesters, e.g. a DMA-style TX feeder and a CPU configuration path. Each requester posts one register read or write at a time. The block grants requesters round-robin, runs a standard two-phase APB transfer (SETUP, then ACCESS) into the I2C top, and returns read data and error status to the granted requester. It sits directly in front of the `i2c` APB ports.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum number of ACCESS cycles spent waiting for PREADY. Legal range 1..255; an 8-bit counter is used.

Ports. Per-requester ports are listed once, with N = 0, 1:
- `PCLK`  in  1  clock; all state changes on the rising edge.
- `PRESETn`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  requester N has a command pending.
- `reqN_write`  in  1  1 = APB write, 0 = APB read.
- `reqN_addr`  in  32  APB address.
- `reqN_wdata`  in  32  write data; ignored for reads.
- `reqN_ready`  out  1  combinational accept. A command is accepted in the cycle where valid & ready are both high.
- `rspN_valid`  out  1  one-cycle pulse when requester N's transfer completes.
- `rspN_rdata`  out  32  read data; holds until requester N's next response.
- `rspN_err`  out  1  PSLVERR or timeout; valid with rspN_valid.
- `M_PADDR`, `M_PWDATA`  out  32  APB address and write data, driven to `i2c`.
- `M_PWRITE`, `M_PSELx`, `M_PENABLE`  out  1  APB control signals.
- `M_PREADY`, `M_PSLVERR`  in  1  APB slave response.
- `M_PRDATA`  in  32  APB read data.
- `busy`  out  1  high in every state except IDLE.
- `grant`  out  1  index of the requester owning the current or most recent transfer.
- `timeout`  out  1  sticky flag; cleared only by reset.

## Operation
- State machine: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If exactly one `reqN_valid` is high, that requester gets `reqN_ready`.
  - If both are high, the requester other than `last_grant` wins.
  - At most one ready is high per cycle.
  - On handshake: latch write, addr and wdata; set `grant` = `last_grant` = N; go to SETUP.
- SETUP: `M_PSELx`=1, `M_PENABLE`=0, address/write/wdata driven from the latches. Always exactly one cycle.
- ACCESS: `M_PSELx`=1, `M_PENABLE`=1.
  - While `M_PREADY`=0, stay in ACCESS.
  - On `M_PREADY`=1: capture `M_PSLVERR` into err.
  - For a read, also capture `M_PRDATA`. For a write, rdata is 0.
  - Then go to RESP.
- RESP:
  - `M_PSELx`=`M_PENABLE`=0.
  - `rsp{grant}_valid`=1 for this single cycle; the `rsp{grant}_rdata` and `rsp{grant}_err` registers update.
  - Go to IDLE.
- The M_PADDR, M_PWDATA and M_PWRITE latches hold their value outside a transfer.
- A requester may drop `reqN_valid` before it is accepted, with no side effects. After acceptance, the command is fully owned by the arbiter.
- There are no request queues. A requester must not issue a new command before its own `rspN_valid`. A new `reqN_valid` while it is not granted simply waits.
- Reset values:
  - All outputs are 0: ready, rsp, rdata, err, M_*, busy, grant, timeout.
  - State = IDLE, `last_grant` = 1, so req0 wins the first tie.
- Reset mid-transfer: outputs go to 0 asynchronously. No response is generated for the aborted command.

## Timing
- Accept cycle is T0 (IDLE). SETUP at T1, ACCESS at T2.
- With zero wait states, RESP (`rspN_valid`) is at T3. Each PREADY-low cycle adds one cycle.
- Minimum period per command is 4 cycles. The next accept can happen at T4.
- Both valid and `last_grant`=0: req1 accepted at T0, req0 at T4. With both held continuously, grants alternate.

## Configuration
- `I2C_APB_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with `M_PREADY`=0.
  - When the count reaches `TIMEOUT_CYCLES` with PREADY still low, the next cycle goes to RESP with err=1 and rdata=0, and `timeout` is set.
  - `M_PSELx` and `M_PENABLE` drop in that RESP cycle.
- Not defined: no counter is built, ACCESS waits indefinitely, and `timeout` is tied to 0.

## Test plan
- req0 write, addr 0x0, wdata 0xA5, PREADY tied 1 -> M_PSELx high T1–T2, M_PENABLE high T2 with M_PWRITE=1 and M_PWDATA=0xA5, rsp0_valid at T3 with rsp0_err=0.
- req0 and req1 both valid straight after reset -> req0 granted first, req1 accepted 4 cycles later. Both re-asserted together -> req1 is not favoured twice; grants alternate.
- req1 read, addr 0x8, PREADY low 3 cycles then high with PRDATA=0x12345678 -> ACCESS lasts 4 cycles, rsp1_rdata=0x12345678, rsp1_valid at T6.
- Write with PSLVERR=1 on the ready cycle -> rspN_err=1 and rdata=0; the next transfer returns err=0.
- With the macro defined, TIMEOUT_CYCLES=4 and PREADY stuck low -> RESP after 4 ACCESS cycles, err=1, timeout=1 stays set. Without the macro -> remains in ACCESS, busy=1, timeout=0.
- PRESETn low during ACCESS -> all outputs 0 immediately, no rspN_valid. After release, a new req0 read completes normally.
